// File: rtl/bcd_out.sv
// Sequential binary-to-BCD converter for the seven-segment display path.
// Iterative shift-add-3 (double dabble), one bit per clock, start/busy/done handshake.
module bcd_out #(
  parameter int WIDTH   = 11,
  parameter int MAX_MAG = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones_value,
  output logic [3:0]       tens_value,
  output logic [3:0]       huns_value,
  output logic [2:0]       digit_en,
  output logic [3:0]       sign,
  output logic             sign_mode,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Segment codes shared with the digit-entry side of the display.
  localparam logic [3:0] SIGN_NEGATIVE = 4'hA;
  localparam logic [3:0] SIGN_OFF      = 4'hF;

  localparam int               CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] MAX_MAG_W = WIDTH'(MAX_MAG);

  function automatic logic [3:0] adj3(input logic [3:0] n);
    if (n >= 4'd5) begin
      adj3 = n + 4'd3;
    end else begin
      adj3 = n;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       huns_q, huns_d;
  logic [2:0]       digit_en_q, digit_en_d;
  logic [3:0]       sign_q, sign_d;
  logic             sign_mode_q, sign_mode_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mag_s;
  logic [11:0]      adj_s;

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    ones_d      = ones_q;
    tens_d      = tens_q;
    huns_d      = huns_q;
    digit_en_d  = digit_en_q;
    sign_d      = sign_q;
    sign_mode_d = sign_mode_q;
    overflow_d  = overflow_q;
    mag_s       = '0;
    adj_s       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d   = bin_value;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Negating -2^(WIDTH-1) wraps to itself, which reads as the right unsigned magnitude.
        if (val_q[WIDTH-1]) begin
          mag_s = ~val_q + WIDTH'(1);
        end else begin
          mag_s = val_q;
        end
        neg_d   = val_q[WIDTH-1];
        mag_d   = mag_s;
        ovf_d   = (mag_s > MAX_MAG_W);
        bcd_d   = 12'd0;
        cnt_d   = CNT_LOAD;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        adj_s          = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
        {bcd_d, mag_d} = {adj_s[10:0], mag_q, 1'b0};
        cnt_d          = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (ovf_q) begin
          huns_d     = 4'd9;
          tens_d     = 4'd9;
          ones_d     = 4'd9;
          digit_en_d = 3'b111;
        end else begin
          huns_d     = bcd_q[11:8];
          tens_d     = bcd_q[7:4];
          ones_d     = bcd_q[3:0];
          digit_en_d = {(bcd_q[11:8] != 4'd0),
                        (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0),
                        1'b1};
        end
        overflow_d  = ovf_q;
        sign_mode_d = neg_q;
        if (neg_q) begin
          sign_d = SIGN_NEGATIVE;
        end else begin
          sign_d = SIGN_OFF;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      val_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= 12'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      huns_q      <= 4'd0;
      digit_en_q  <= 3'b001;
      sign_q      <= SIGN_OFF;
      sign_mode_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      huns_q      <= huns_d;
      digit_en_q  <= digit_en_d;
      sign_q      <= sign_d;
      sign_mode_q <= sign_mode_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_value = ones_q;
  assign tens_value = tens_q;
  assign huns_value = huns_q;
  assign digit_en   = digit_en_q;
  assign sign       = sign_q;
  assign sign_mode  = sign_mode_q;
  assign overflow   = overflow_q;

endmodule
